// File: rtl/key_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_led_pkg
// Description : Shared widths, mode encodings, key roles and LED pattern
//               generator for the key/LED front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package key_led_pkg;

    localparam int KEY_W = 4;
    localparam int LED_W = 4;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_RUN   = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_COUNT = 2'd3;

    localparam int KEY_NEXT  = 0;
    localparam int KEY_PREV  = 1;
    localparam int KEY_PAUSE = 2;
    localparam int KEY_CLEAR = 3;

    // RUN and BLINK only look at the low phase bits; COUNT shows all four.
    function automatic logic [LED_W-1:0] led_pattern(input logic [1:0] mode,
                                                     input logic [3:0] phase);
        logic [LED_W-1:0] pat;
        pat = '0;
        case (mode)
            MODE_RUN:   pat = LED_W'(4'b0001 << phase[1:0]);
            MODE_BLINK: pat = phase[0] ? '0 : '1;
            MODE_COUNT: pat = LED_W'(phase);
            default:    pat = '0;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchronizer, shared-counter debounce and press
//               (falling-edge) detection for the active-low key vector.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] press,
    output logic             key_flag
);

    localparam int                  c_cnt_w = $clog2(DEBOUNCE_CYC);
    localparam logic [c_cnt_w-1:0]  c_load  = c_cnt_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

    logic [KEY_W-1:0]   r_sync1;
    logic [KEY_W-1:0]   r_key_s;
    logic [KEY_W-1:0]   r_key_s_d;
    logic [c_cnt_w-1:0] r_db_cnt;
    logic [KEY_W-1:0]   r_key_db;
    logic [KEY_W-1:0]   r_key_db_d;
    logic [KEY_W-1:0]   r_press;
    logic               r_key_flag;
    logic [KEY_W-1:0]   w_fall;

    assign w_fall = r_key_db_d & ~r_key_db;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1    <= '1;
            r_key_s    <= '1;
            r_key_s_d  <= '1;
            r_db_cnt   <= '0;
            r_key_db   <= '1;
            r_key_db_d <= '1;
            r_press    <= '0;
            r_key_flag <= 1'b0;
        end else begin
            r_sync1   <= key;
            r_key_s   <= r_sync1;
            r_key_s_d <= r_key_s;
            // Any movement on the synchronized vector restarts the window.
            if (r_key_s != r_key_s_d) begin
                r_db_cnt <= c_load;
            end else if (r_db_cnt != '0) begin
                r_db_cnt <= r_db_cnt - c_one;
                if (r_db_cnt == c_one) begin
                    r_key_db <= r_key_s;
                end
            end
            r_key_db_d <= r_key_db;
            r_press    <= w_fall;
            r_key_flag <= |w_fall;
        end
    end

    assign press    = r_press;
    assign key_flag = r_key_flag;

endmodule
`default_nettype wire

// File: rtl/key_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_led_ctrl
// Description : Key front-end plus mode/pause control, step prescaler,
//               phase counter and registered LED pattern output.
// Revision    : 1.0 - initial release
// ============================================================================
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int STEP_CYC     = 12_500_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [KEY_W-1:0] key,
    output logic [LED_W-1:0] led_state,
    output logic [1:0]       mode,
    output logic             key_flag
);

    localparam int                    c_presc_w   = $clog2(STEP_CYC);
    localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(STEP_CYC - 1);
    localparam logic [c_presc_w-1:0]  c_presc_one = c_presc_w'(1);

    logic [KEY_W-1:0]     w_press;
    logic                 w_key_flag;
    logic [1:0]           r_mode;
    logic [1:0]           w_mode_nxt;
    logic                 r_paused;
    logic [c_presc_w-1:0] r_presc;
    logic [3:0]           r_phase;
    logic [LED_W-1:0]     r_led;
    logic                 w_mode_chg;
    logic                 w_clear;
    logic                 w_tick;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .press     (w_press),
        .key_flag  (w_key_flag)
    );

    // NEXT has priority over PREV when both land in the same accepted vector.
    always_comb begin
        w_mode_nxt = r_mode;
        if (w_key_flag) begin
            if (w_press[KEY_NEXT]) begin
                w_mode_nxt = r_mode + 2'd1;
            end else if (w_press[KEY_PREV]) begin
                w_mode_nxt = r_mode - 2'd1;
            end
        end
    end

    assign w_mode_chg = w_key_flag & (w_press[KEY_NEXT] | w_press[KEY_PREV]);
    assign w_clear    = w_mode_chg | (w_key_flag & w_press[KEY_CLEAR]);
    assign w_tick     = ~r_paused & (r_presc == c_presc_max);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode   <= MODE_OFF;
            r_paused <= 1'b0;
            r_presc  <= '0;
            r_phase  <= '0;
            r_led    <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            if (w_key_flag && w_press[KEY_PAUSE]) begin
                r_paused <= ~r_paused;
            end
            if (w_clear) begin
                r_presc <= '0;
                r_phase <= '0;
            end else if (!r_paused) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_phase <= r_phase + 4'd1;
                end else begin
                    r_presc <= r_presc + c_presc_one;
                end
            end
            r_led <= led_pattern(r_mode, r_phase);
        end
    end

    assign led_state = r_led;
    assign mode      = r_mode;
    assign key_flag  = w_key_flag;

endmodule
`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_led_ctrl
// Description : Scoreboard bench: the driver predicts key_flag, mode and
//               led_state change events; a monitor pops them as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_led_ctrl;

    localparam int DEB  = 4;
    localparam int STEP = 3;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] key       = 4'hF;
    logic [3:0] led_state;
    logic [1:0] mode;
    logic       key_flag;

    int  cyc     = 0;
    int  checks  = 0;
    int  errors  = 0;
    int  n_flags = 0;
    bit  done    = 1'b0;

    ev_t flag_q[$];
    ev_t led_q[$];
    ev_t mode_q[$];

    // Reference state: raw sample history, accepted vector, abstract time.
    logic [3:0] hist[$];
    logic [3:0] db_m1, db_m2, press_m;
    logic [1:0] m_mode;
    bit         m_paused;
    int         m_run;
    logic [3:0] m_led;

    key_led_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .STEP_CYC     (STEP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .led_state (led_state),
        .mode      (mode),
        .key_flag  (key_flag)
    );

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [3:0] pat(input logic [1:0] md, input int steps);
        case (md)
            2'd0:    return 4'h0;
            2'd1:    return 4'b0001 << (steps % 4);
            2'd2:    return ((steps % 2) == 0) ? 4'hF : 4'h0;
            default: return 4'(steps % 16);
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (DEB + 3) hist.push_back(4'hF);
        db_m1    = 4'hF;
        db_m2    = 4'hF;
        press_m  = 4'h0;
        m_mode   = 2'd0;
        m_paused = 1'b0;
        m_run    = 0;
        m_led    = 4'h0;
    endtask

    // Predict the DUT state right after clock edge n, given raw sample s.
    task automatic model_edge(input int n, input logic [3:0] s);
        logic [3:0] a, db_new, press_new, led_new;
        logic [1:0] mode_new;
        bit         stable, paused_new;
        int         run_new;
        hist.push_back(s);
        void'(hist.pop_front());
        // A value is accepted once DEB consecutive synchronized samples agree
        // right after a change.
        a = hist[DEB];
        stable = 1'b1;
        for (int k = 1; k <= DEB; k++) if (hist[k] != a) stable = 1'b0;
        db_new    = (stable && hist[0] != a) ? a : db_m1;
        press_new = db_m2 & ~db_m1;
        led_new   = pat(m_mode, m_run / STEP);
        mode_new  = m_mode;
        paused_new = m_paused;
        run_new   = m_paused ? m_run : m_run + 1;
        if (press_m != 4'h0) begin
            if (press_m[0])      mode_new = m_mode + 2'd1;
            else if (press_m[1]) mode_new = m_mode - 2'd1;
            if (press_m[2])      paused_new = !m_paused;
            if (press_m[0] || press_m[1] || press_m[3]) run_new = 0;
        end
        if (press_new != 4'h0)  flag_q.push_back('{n, press_new});
        if (led_new != m_led)   led_q.push_back('{n, led_new});
        if (mode_new != m_mode) mode_q.push_back('{n, {2'b00, mode_new}});
        db_m2    = db_m1;
        db_m1    = db_new;
        press_m  = press_new;
        m_mode   = mode_new;
        m_paused = paused_new;
        m_run    = run_new;
        m_led    = led_new;
    endtask

    task automatic step(input logic [3:0] k);
        @(negedge sys_clk);
        key = k;
        model_edge(cyc + 1, k);
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'hF);
    endtask

    task automatic press(input logic [3:0] mask);
        repeat (DEB + 4) step(~mask);
        repeat (DEB + 4) step(4'hF);
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_val("reset led_state", int'(led_state), 0);
        check_val("reset mode", int'(mode), 0);
        check_val("reset key_flag", int'(key_flag), 0);
        flag_q.delete();
        led_q.delete();
        mode_q.delete();
        model_reset();
        repeat (hold) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        key = 4'hF;
        model_edge(cyc + 1, 4'hF);
    endtask

    // Monitor: every visible output event must match the oldest prediction.
    initial begin
        logic [3:0] last_led;
        logic [1:0] last_mode;
        ev_t        e;
        last_led  = 4'h0;
        last_mode = 2'd0;
        forever begin
            @(negedge sys_clk);
            if (done) break;
            if (!sys_rst_n) begin
                last_led  = 4'h0;
                last_mode = 2'd0;
                continue;
            end
            if (key_flag) begin
                n_flags++;
                checks++;
                if (flag_q.size() == 0) begin
                    errors++;
                    $display("FAIL key_flag: unexpected pulse at cycle %0d", cyc);
                end else begin
                    e = flag_q.pop_front();
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL key_flag: seen at cycle %0d, required at cycle %0d", cyc, e.cyc);
                    end
                end
            end
            if (led_state !== last_led) begin
                checks++;
                if (led_q.size() == 0) begin
                    errors++;
                    $display("FAIL led_state: unexpected change to %b at cycle %0d", led_state, cyc);
                end else begin
                    e = led_q.pop_front();
                    if (e.cyc != cyc || e.val !== led_state) begin
                        errors++;
                        $display("FAIL led_state: got %b at cycle %0d, required %b at cycle %0d",
                                 led_state, cyc, e.val, e.cyc);
                    end
                end
                last_led = led_state;
            end
            if (mode !== last_mode) begin
                checks++;
                if (mode_q.size() == 0) begin
                    errors++;
                    $display("FAIL mode: unexpected change to %0d at cycle %0d", mode, cyc);
                end else begin
                    e = mode_q.pop_front();
                    if (e.cyc != cyc || e.val[1:0] !== mode) begin
                        errors++;
                        $display("FAIL mode: got %0d at cycle %0d, required %0d at cycle %0d",
                                 mode, cyc, e.val[1:0], e.cyc);
                    end
                end
                last_mode = mode;
            end
            while (flag_q.size() > 0 && flag_q[0].cyc < cyc) begin
                e = flag_q.pop_front(); checks++; errors++;
                $display("FAIL key_flag: missing pulse, required at cycle %0d", e.cyc);
            end
            while (led_q.size() > 0 && led_q[0].cyc < cyc) begin
                e = led_q.pop_front(); checks++; errors++;
                $display("FAIL led_state: missing change to %b, required at cycle %0d", e.val, e.cyc);
            end
            while (mode_q.size() > 0 && mode_q[0].cyc < cyc) begin
                e = mode_q.pop_front(); checks++; errors++;
                $display("FAIL mode: missing change to %0d, required at cycle %0d", e.val[1:0], e.cyc);
            end
        end
    end

    initial begin
        int         f0;
        logic [3:0] mask;
        model_reset();
        do_reset(3);
        idle(5);

        // Bounce on key[0], then a clean hold: one accepted press.
        f0 = n_flags;
        for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? 4'hE : 4'hF);
        repeat (10) step(4'hE);
        repeat (DEB + 4) step(4'hF);
        check_val("bounce flag count", n_flags - f0, 1);
        check_val("bounce mode", int'(mode), 1);

        idle(20);                   // RUN stepping
        press(4'b0010);             // 1 -> 0
        press(4'b0010);             // 0 -> 3 (wrap)
        check_val("prev wrap mode", int'(mode), 3);
        idle(55);                   // COUNT wraps 1111 -> 0000
        press(4'b0010);             // 3 -> 2 BLINK
        press(4'b0100);             // pause
        idle(20);
        press(4'b1000);             // clear while paused -> 1111
        check_val("clear in pause led", int'(led_state), 15);
        press(4'b0100);             // resume
        idle(12);
        f0 = n_flags;
        press(4'b0011);             // NEXT wins over PREV
        check_val("simultaneous flag count", n_flags - f0, 1);
        check_val("simultaneous mode", int'(mode), 3);
        idle(10);
        do_reset(2);                // mid-pattern reset
        idle(10);

        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(1, 15));
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(1, DEB - 1)) step(~mask);
                repeat ($urandom_range(1, DEB - 1)) step(4'hF);
            end
            repeat ($urandom_range(DEB, DEB + 6)) step(~mask);
            repeat ($urandom_range(DEB + 2, DEB + 6)) step(4'hF);
            idle($urandom_range(0, 30));
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
        end

        @(negedge sys_clk);
        #1;
        done = 1'b1;
        check_val("pending key_flag events", flag_q.size(), 0);
        check_val("pending led_state events", led_q.size(), 0);
        check_val("pending mode events", mode_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
